// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer width helper, read-mode encodings
// and parameter-range checks used by the sync and async FIFOs.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Elaboration-time range check; instantiate inside a module body.
`define FIFO_CHECK_RANGE(lbl, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin : lbl \
    $error("fifo parameter out of range"); \
  end

package fifo_pkg;

  localparam int FWFT_STD  = 0;
  localparam int FWFT_FALL = 1;

  typedef enum logic {
    FWFT_MODE_STD  = 1'b0,
    FWFT_MODE_FALL = 1'b1
  } fwft_mode_e;

  function automatic int PTR_W(input int asize);
    return asize + 1;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_thresh_if.sv
// Producer/consumer bundle for sync_fifo_thresh.
// master drives requests, slave is the FIFO itself.
interface sync_fifo_thresh_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 3
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             w_almost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             r_almost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  wfull, w_almost_full, rdata, rempty,
        input  r_almost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output wfull, w_almost_full, rdata, rempty,
        output r_almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE storage with synchronous write; read port is
// combinational (fall-through) or registered with enable.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 3,
    parameter int FWFT  = FWFT_STD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    localparam int DEPTH = 2 ** ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (FWFT == FWFT_FALL) begin : g_fwft
            // Enable and reset have no role on a combinational port.
            logic unused_fwft;
            assign unused_fwft = re ^ rst;
            assign rdata = mem[raddr];
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate
endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, threshold flags,
// optional fall-through read and sticky overflow/underflow.
module sync_fifo_thresh
    import fifo_pkg::*;
#(
    parameter int DSIZE             = 8,
    parameter int ASIZE             = 3,
    parameter int ALMOST_FULL_SIZE  = 5,
    parameter int ALMOST_EMPTY_SIZE = 3,
    parameter int FWFT              = FWFT_STD
) (
    input logic               clk,
    input logic               rst,
    sync_fifo_thresh_if.slave f
);
    localparam int DEPTH = 2 ** ASIZE;
    localparam int PW    = PTR_W(ASIZE);

    `FIFO_CHECK_RANGE(g_chk_dsize, DSIZE, 1, 1024)
    `FIFO_CHECK_RANGE(g_chk_asize, ASIZE, 1, 16)
    `FIFO_CHECK_RANGE(g_chk_af, ALMOST_FULL_SIZE, 1, DEPTH)
    `FIFO_CHECK_RANGE(g_chk_ae, ALMOST_EMPTY_SIZE, 0, DEPTH - 1)
    `FIFO_CHECK_RANGE(g_chk_fwft, FWFT, FWFT_STD, FWFT_FALL)

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(ALMOST_FULL_SIZE);
    localparam logic [PW-1:0] AE_C    = PW'(ALMOST_EMPTY_SIZE);

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    count;
    logic [PW-1:0]    count_nxt;
    logic             wfull;
    logic             rempty;
    logic             w_almost_full;
    logic             r_almost_empty;
    logic             overflow;
    logic             underflow;
    logic             wr_ok;
    logic             rd_ok;
    logic             ovf_evt;
    logic             ufl_evt;
    logic [DSIZE-1:0] mem_rdata;

    // Acceptance uses the registered flags from before the edge.
    assign wr_ok   = f.winc & ~wfull;
    assign rd_ok   = f.rinc & ~rempty;
    assign ovf_evt = f.winc & wfull;
    assign ufl_evt = f.rinc & rempty;

    assign count_nxt = count + PW'(wr_ok) - PW'(rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            wfull          <= 1'b0;
            rempty         <= 1'b1;
            w_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            count          <= count_nxt;
            wfull          <= (count_nxt == DEPTH_C);
            rempty         <= (count_nxt == '0);
            w_almost_full  <= (count_nxt >= AF_C);
            r_almost_empty <= (count_nxt <= AE_C);
        end
    end

    // A new error in the clearing cycle keeps its flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt | (overflow & ~f.clr_err);
            underflow <= ufl_evt | (underflow & ~f.clr_err);
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .FWFT  (FWFT)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (f.wdata),
        .re    (rd_ok),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == FWFT_FALL) begin : g_rd_fwft
            assign f.rdata = rempty ? '0 : mem_rdata;
        end else begin : g_rd_std
            assign f.rdata = mem_rdata;
        end
    endgenerate

    assign f.count          = count;
    assign f.wfull          = wfull;
    assign f.rempty         = rempty;
    assign f.w_almost_full  = w_almost_full;
    assign f.r_almost_empty = r_almost_empty;
    assign f.overflow       = overflow;
    assign f.underflow      = underflow;
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh: standard-mode instance a,
// fall-through instance b, sharing clock and reset.
module tb_sync_fifo_thresh;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sync_fifo_thresh_if #(.DSIZE(8), .ASIZE(3)) ia ();
    sync_fifo_thresh_if #(.DSIZE(8), .ASIZE(3)) ib ();

    sync_fifo_thresh #(.FWFT(0)) dut_a (.clk(clk), .rst(rst), .f(ia));
    sync_fifo_thresh #(.FWFT(1)) dut_b (.clk(clk), .rst(rst), .f(ib));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_count"}, 32'(ia.count), 0);
        chk({tag, "_wfull"}, 32'(ia.wfull), 0);
        chk({tag, "_waf"}, 32'(ia.w_almost_full), 0);
        chk({tag, "_rempty"}, 32'(ia.rempty), 1);
        chk({tag, "_rae"}, 32'(ia.r_almost_empty), 1);
        chk({tag, "_rdata"}, 32'(ia.rdata), 0);
        chk({tag, "_ovf"}, 32'(ia.overflow), 0);
        chk({tag, "_ufl"}, 32'(ia.underflow), 0);
    endtask

    initial begin
        ia.winc = 0; ia.wdata = 0; ia.rinc = 0; ia.clr_err = 0;
        ib.winc = 0; ib.wdata = 0; ib.rinc = 0; ib.clr_err = 0;
        cyc();
        cyc();
        chk_reset_a("rst0");
        chk("rst0_b_rempty", 32'(ib.rempty), 1);
        rst = 0;

        // Fill with 0x01..0x08.
        for (int i = 1; i <= 8; i++) begin
            ia.winc = 1; ia.wdata = 8'(i);
            cyc();
            chk("fill_count", 32'(ia.count), 32'(i));
            chk("fill_waf", 32'(ia.w_almost_full), 32'(i >= 5));
            chk("fill_wfull", 32'(ia.wfull), 32'(i == 8));
            chk("fill_rae", 32'(ia.r_almost_empty), 32'(i <= 3));
            chk("fill_rempty", 32'(ia.rempty), 0);
        end
        ia.wdata = 8'h99;
        cyc();
        ia.winc = 0;
        chk("ovf_set", 32'(ia.overflow), 1);
        chk("ovf_count", 32'(ia.count), 8);
        ia.clr_err = 1;
        cyc();
        ia.clr_err = 0;
        chk("ovf_clr", 32'(ia.overflow), 0);

        // Drain in order.
        ia.rinc = 1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("drain_rdata", 32'(ia.rdata), 32'(i));
            chk("drain_count", 32'(ia.count), 32'(8 - i));
            chk("drain_rae", 32'(ia.r_almost_empty), 32'((8 - i) <= 3));
            chk("drain_rempty", 32'(ia.rempty), 32'(i == 8));
        end
        cyc();
        ia.rinc = 0;
        chk("ufl_set", 32'(ia.underflow), 1);
        chk("ufl_rdata_hold", 32'(ia.rdata), 8'h08);
        chk("ufl_count", 32'(ia.count), 0);
        ia.clr_err = 1;
        cyc();
        ia.clr_err = 0;
        chk("ufl_clr", 32'(ia.underflow), 0);

        // Preload 0x10..0x13, then 20 cycles of write+read at count 4.
        for (int i = 0; i < 4; i++) begin
            ia.winc = 1; ia.wdata = 8'(8'h10 + i);
            cyc();
        end
        ia.rinc = 1;
        for (int k = 0; k < 20; k++) begin
            ia.wdata = 8'(8'h14 + k);
            cyc();
            chk("sim_count", 32'(ia.count), 4);
            chk("sim_rdata", 32'(ia.rdata), 32'(8'h10 + k));
        end
        ia.rinc = 0;

        // Queue now 0x24..0x27; top up to full with 0x28..0x2B.
        for (int i = 0; i < 4; i++) begin
            ia.wdata = 8'(8'h28 + i);
            cyc();
        end
        ia.winc = 0;
        chk("full_wfull", 32'(ia.wfull), 1);
        ia.winc = 1; ia.rinc = 1; ia.wdata = 8'hEE;
        cyc();
        ia.rinc = 0;
        chk("fullb_count", 32'(ia.count), 7);
        chk("fullb_ovf", 32'(ia.overflow), 1);
        chk("fullb_rdata", 32'(ia.rdata), 8'h24);
        chk("fullb_wfull", 32'(ia.wfull), 0);
        ia.wdata = 8'h2C;
        cyc();
        chk("refill_count", 32'(ia.count), 8);
        ia.wdata = 8'hEF; ia.clr_err = 1;
        cyc();
        ia.winc = 0;
        chk("clr_vs_ovf", 32'(ia.overflow), 1);
        cyc();
        ia.clr_err = 0;
        chk("clr_only", 32'(ia.overflow), 0);

        // Read two to reach count 6, then reset mid-cycle.
        ia.rinc = 1;
        cyc();
        chk("pre_rst_rdata0", 32'(ia.rdata), 8'h25);
        cyc();
        ia.rinc = 0;
        chk("pre_rst_rdata1", 32'(ia.rdata), 8'h26);
        chk("pre_rst_count", 32'(ia.count), 6);
        ia.winc = 1; ia.wdata = 8'h01;
        #2;
        rst = 1;
        #1;
        chk_reset_a("rst_async");
        ia.winc = 0;
        cyc();
        rst = 0;

        // First write after reset, read it back.
        ia.winc = 1; ia.wdata = 8'h77;
        cyc();
        ia.winc = 0; ia.rinc = 1;
        cyc();
        ia.rinc = 0;
        chk("post_rst_rdata", 32'(ia.rdata), 8'h77);
        chk("post_rst_empty", 32'(ia.rempty), 1);

        // Empty boundary: write accepted, read flagged.
        ia.winc = 1; ia.rinc = 1; ia.wdata = 8'h55;
        cyc();
        ia.winc = 0; ia.rinc = 0;
        chk("emptyb_count", 32'(ia.count), 1);
        chk("emptyb_ufl", 32'(ia.underflow), 1);
        chk("emptyb_rempty", 32'(ia.rempty), 0);
        chk("emptyb_rdata", 32'(ia.rdata), 8'h77);

        // Fall-through instance.
        chk("fwft_empty0", 32'(ib.rempty), 1);
        ib.winc = 1; ib.wdata = 8'hA5;
        cyc();
        ib.winc = 0;
        chk("fwft_rdata", 32'(ib.rdata), 8'hA5);
        chk("fwft_rempty", 32'(ib.rempty), 0);
        chk("fwft_count", 32'(ib.count), 1);
        ib.rinc = 1;
        cyc();
        ib.rinc = 0;
        chk("fwft_pop_empty", 32'(ib.rempty), 1);
        chk("fwft_pop_count", 32'(ib.count), 0);
        ib.winc = 1; ib.wdata = 8'h11;
        cyc();
        ib.wdata = 8'h22;
        cyc();
        ib.winc = 0;
        chk("fwft_head0", 32'(ib.rdata), 8'h11);
        ib.rinc = 1;
        cyc();
        ib.rinc = 0;
        chk("fwft_head1", 32'(ib.rdata), 8'h22);
        chk("fwft_count1", 32'(ib.count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
